muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// Parametrised RV32M/RV64M multiply/divide execution unit for the EX stage of the pipelined CPU.
// Accepts one M-extension operation per START pulse and returns RESULT with a one-cycle DONE pulse.
// Asserts BUSY while an operation is in flight so the CPU can stall its pipeline registers through busywait.
// Aborts an in-flight operation on FLUSH, for example when a branch resolves taken in EX.
// PARAMETERS
// XLEN          32  operand/result width; legal values are 32 and 64
// MUL_ITERATIVE 0   0 = single-cycle array multiply (L=1); 1 = shift-add multiply (L=XLEN+1)
// PORTS
// CLK     in  1     clock, rising edge
// RST     in  1     synchronous active-high reset
// START   in  1     request; sampled only in IDLE or DONE
// OP      in  3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// DATA1   in  XLEN  rs1 operand (dividend / multiplicand); captured on accept
// DATA2   in  XLEN  rs2 operand (divisor / multiplier); captured on accept
// FLUSH   in  1     abort current operation
// BUSY    out 1     registered; high in MUL_RUN and DIV_RUN
// DONE    out 1     registered one-cycle pulse; RESULT is valid in this cycle
// RESULT  out XLEN  registered; holds its value until the next DONE
// BEHAVIOUR
// - Reset: state=IDLE; BUSY=0, DONE=0, RESULT=0; counter and operand registers cleared.
// - States: IDLE, MUL_RUN, DIV_RUN, DONE.
//   IDLE/DONE + START + !FLUSH -> MUL_RUN (OP[2]=0 & MUL_ITERATIVE=1) | DIV_RUN (normal divide) | DONE (shortcut cases)
//   MUL_RUN/DIV_RUN: counter counts down from XLEN-1; at 0 -> DONE
//   DONE: DONE=1 for exactly one cycle -> IDLE, or back-to-back accept of a new START
// - Latency L = cycles from the accepting edge to DONE high:
//   - fast MUL*: L=1
//   - iterative MUL* and normal div/rem: L=XLEN+1
//   - shortcuts: L=1
// - Multiply: compute the 2*XLEN-bit product of the extended operands.
//   - Signedness: MULH is s*s; MULHSU is s(rs1)*u(rs2); MULHU is u*u.
//   - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
// - Divide: restoring, one quotient bit per cycle on magnitudes.
//   - Signed ops take absolute values at accept and negate at DONE.
//   - Quotient sign = sign(rs1) ^ sign(rs2). Remainder sign = sign(rs1).
// - Shortcuts (RISC-V spec):
//   - Divisor 0: DIV/DIVU return all ones; REM/REMU return rs1.
//   - DIV of -2^(XLEN-1) by -1 returns -2^(XLEN-1); REM of the same returns 0.
// - START while BUSY=1 is ignored. No queueing; operands are not re-sampled.
// - FLUSH in any state -> IDLE at the next edge.
//   - DONE is not pulsed and RESULT is unchanged.
//   - FLUSH with START in the same cycle: FLUSH wins and the request is dropped.
// - FLUSH in the DONE cycle: DONE is still high in that cycle (already registered); no new accept.
// - RST mid-operation: identical to reset, no DONE.
// - OP and DATA inputs are don't-care outside the accepting cycle.
// STRUCTURE
// - Package muldiv_pkg holds:
//   - OP_* funct3 localparams
//   - state encoding: IDLE=2'd0, MUL_RUN=2'd1, DIV_RUN=2'd2, DONE=2'd3
//   - counter width $clog2(XLEN)
// - Sub-module div_iter (XLEN param) holds the restoring divider datapath: remainder/quotient shift registers and the subtract step.
//   - Its ports are load, step, divisor, dividend, quotient and remainder.
// - The top holds the FSM, counter, sign fix-up, shortcut detection and the multiplier (array or shift-add, selected by a generate on MUL_ITERATIVE).
// TESTING
// 1. MUL_ITERATIVE=0, XLEN=32: MUL 7*-3 -> RESULT=0xFFFFFFEB, DONE at L=1.
//    MULHU 0xFFFFFFFF*0xFFFFFFFF -> RESULT=0xFFFFFFFE.
// 2. DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 14.
//    Each has DONE at exactly L=33, and BUSY is high for 32 cycles.
// 3. Shortcuts, each with DONE at L=1 and BUSY never high:
//    - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5
//    - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0
// 4. FLUSH at cycle 10 of a DIV: state returns to IDLE and DONE is never pulsed.
//    RESULT keeps the prior value. A START in the flush cycle is dropped.
// 5. Back-to-back: START held high through a DONE cycle with a new OP.
//    Second result arrives at L after the DONE edge. START during BUSY is ignored (a single DONE per accept).
// 6. XLEN=64, MUL_ITERATIVE=1: MULHSU -1*2 -> 0xFFFFFFFFFFFFFFFF at L=65.
//    RST asserted mid-run clears all outputs to 0 at the next edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// The load cycle already performs the first iteration, so after XLEN-1 steps the result is final.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  // Returns {next remainder, next quotient}; the quotient register doubles as the dividend shifter.
  function automatic logic [2*XLEN-1:0] restore_step(input logic [XLEN-1:0] rem,
                                                     input logic [XLEN-1:0] quo,
                                                     input logic [XLEN-1:0] dvs);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[XLEN]) return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
  endfunction

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      {rem_d, quo_d} = restore_step('0, dividend, divisor);
      dvs_d          = divisor;
    end else if (step) begin
      {rem_d, quo_d} = restore_step(rem_q, quo_q, dvs_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: FSM, sign handling, divide shortcuts and a
// single-cycle or shift-add multiplier selected by MUL_ITERATIVE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_ITERATIVE = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int              CNT_W   = cnt_width(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_q, neg_d;
  logic              hi_q, hi_d;
  logic              rem_sel_q, rem_sel_d;

  logic              idle_like, accept, last_iter;
  logic              a_neg, b_neg, div_zero, div_ovf, shortcut;
  logic [XLEN-1:0]   mag_a, mag_b, short_res;
  logic [XLEN-1:0]   quotient, remainder, div_mag, div_res;
  logic              mul_hi, mul_neg;
  logic [2*XLEN-1:0] mul_mag, mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = idle_like && START && !FLUSH;
  assign last_iter = (cnt_q == '0);

  // Both datapaths work on magnitudes; the sign is re-applied on the way out.
  assign a_neg = rs1_signed(OP) && DATA1[XLEN-1];
  assign b_neg = rs2_signed(OP) && DATA2[XLEN-1];
  assign mag_a = a_neg ? -DATA1 : DATA1;
  assign mag_b = b_neg ? -DATA2 : DATA2;

  assign div_zero  = (DATA2 == '0);
  assign div_ovf   = ((OP == OP_DIV) || (OP == OP_REM)) && (DATA1 == MIN_NEG) && (DATA2 == '1);
  assign shortcut  = OP[2] && (div_zero || div_ovf);
  assign short_res = div_zero ? (OP[1] ? DATA1 : '1) : (OP[1] ? '0 : MIN_NEG);

  div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .step     ((state_q == ST_DIV_RUN) && !last_iter),
    .divisor  (mag_b),
    .dividend (mag_a),
    .quotient (quotient),
    .remainder(remainder)
  );

  assign div_mag = rem_sel_q ? remainder : quotient;
  assign div_res = neg_q ? -div_mag : div_mag;

  generate
    if (MUL_ITERATIVE != 0) begin : g_mul_iter
      logic [2*XLEN-1:0] prod_q, prod_d, prod_nxt;
      logic [XLEN-1:0]   mcand_q, mcand_d;
      logic [XLEN:0]     upper_sum;

      // The final add/shift is taken combinationally in the last MUL_RUN cycle.
      always_comb begin
        upper_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nxt  = {upper_sum, prod_q[XLEN-1:1]};
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        if (accept) begin
          prod_d  = {{XLEN{1'b0}}, mag_b};
          mcand_d = mag_a;
        end else if (state_q == ST_MUL_RUN) begin
          prod_d  = prod_nxt;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          prod_q  <= '0;
          mcand_q <= '0;
        end else begin
          prod_q  <= prod_d;
          mcand_q <= mcand_d;
        end
      end

      assign mul_mag = prod_nxt;
    end else begin : g_mul_fast
      assign mul_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    end
  endgenerate

  // In the accept cycle the select bits come straight from the request.
  assign mul_hi   = idle_like ? hi_d : hi_q;
  assign mul_neg  = idle_like ? neg_d : neg_q;
  assign mul_prod = mul_neg ? -mul_mag : mul_mag;
  assign mul_res  = mul_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

  always_comb begin
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    rem_sel_d = rem_sel_q;
    if (accept) begin
      cnt_d     = CNT_W'(XLEN - 1);
      neg_d     = (OP[2] && OP[1]) ? a_neg : (a_neg ^ b_neg);
      hi_d      = (OP[1:0] != 2'b00);
      rem_sel_d = OP[1];
    end else if (((state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN)) && !last_iter) begin
      cnt_d     = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      hi_q      <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (!START)      state_d = ST_IDLE;
          else if (!OP[2]) state_d = (MUL_ITERATIVE != 0) ? ST_MUL_RUN : ST_DONE;
          else             state_d = shortcut ? ST_DONE : ST_DIV_RUN;
        end
        ST_MUL_RUN, ST_DIV_RUN: if (last_iter) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d   = (state_d == ST_MUL_RUN) || (state_d == ST_DIV_RUN);
    done_d   = (state_d == ST_DONE);
    result_d = result_q;
    if (state_d == ST_DONE) begin
      case (state_q)
        ST_MUL_RUN: result_d = mul_res;
        ST_DIV_RUN: result_d = div_res;
        default:    result_d = OP[2] ? short_res : mul_res;
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit single-cycle-multiply instance and
// a 64-bit shift-add instance, checking result, latency and BUSY duration.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  exp_t q32[$];
  exp_t q64[$];
  bit   seen;

  logic        rst32, start32, flush32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] d1_32, d2_32, res32;
  logic        rst64, start64, flush64, busy64, done64;
  logic [2:0]  op64;
  logic [63:0] d1_64, d2_64, res64;

  muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(0)) u_dut32 (
    .CLK(clk), .RST(rst32), .START(start32), .OP(op32), .DATA1(d1_32), .DATA2(d2_32),
    .FLUSH(flush32), .BUSY(busy32), .DONE(done32), .RESULT(res32)
  );

  muldiv_unit #(.XLEN(64), .MUL_ITERATIVE(1)) u_dut64 (
    .CLK(clk), .RST(rst64), .START(start64), .OP(op64), .DATA1(d1_64), .DATA2(d2_64),
    .FLUSH(flush64), .BUSY(busy64), .DONE(done64), .RESULT(res64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) chk("spurious_done32", 64'(done32), 64'd0);
      else begin
        e = q32.pop_front();
        chk("result32", 64'(res32), e.res);
        chk("latency32", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (done64) begin
      if (q64.size() == 0) chk("spurious_done64", 64'(done64), 64'd0);
      else begin
        e = q64.pop_front();
        chk("result64", res64, e.res);
        chk("latency64", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic run_op(input bit w64, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] want, input int lat,
                        input int busy_want);
    int busy_n;
    bit got_done;
    busy_n   = 0;
    got_done = 0;
    @(negedge clk);
    if (w64) begin
      start64 = 1'b1; op64 = op; d1_64 = a; d2_64 = b;
      q64.push_back('{want, cyc + lat});
    end else begin
      start32 = 1'b1; op32 = op; d1_32 = a[31:0]; d2_32 = b[31:0];
      q32.push_back('{64'(want[31:0]), cyc + lat});
    end
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (w64 ? busy64 : busy32) busy_n++;
      if (w64 ? done64 : done32) got_done = 1;
      else @(negedge clk);
    end
    chk("done_timeout", 64'(got_done), 64'd1);
    chk("busy_cycles", 64'(busy_n), 64'(busy_want));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst32 = 1'b1; start32 = 1'b0; flush32 = 1'b0; op32 = '0; d1_32 = '0; d2_32 = '0;
    rst64 = 1'b1; start64 = 1'b0; flush64 = 1'b0; op64 = '0; d1_64 = '0; d2_64 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_res32", 64'(res32), 64'd0);
    chk("rst_busy64", 64'(busy64), 64'd0);
    chk("rst_done64", 64'(done64), 64'd0);
    chk("rst_res64", res64, 64'd0);
    rst32 = 1'b0;
    rst64 = 1'b0;

    // 32-bit multiplies
    run_op(0, OP_MUL,    64'd7,          -64'sd3,        64'hFFFFFFEB, 1, 0);
    run_op(0, OP_MULHU,  64'hFFFFFFFF,   64'hFFFFFFFF,   64'hFFFFFFFE, 1, 0);
    run_op(0, OP_MULH,   64'hFFFFFFFF,   64'hFFFFFFFF,   64'h00000000, 1, 0);
    run_op(0, OP_MULHSU, 64'hFFFFFFFF,   64'd2,          64'hFFFFFFFF, 1, 0);
    run_op(0, OP_MULH,   64'h80000000,   64'h80000000,   64'h40000000, 1, 0);
    // 32-bit divides
    run_op(0, OP_DIV,    -64'sd20,       64'd3,          64'hFFFFFFFA, 33, 32);
    run_op(0, OP_REM,    -64'sd20,       64'd3,          64'hFFFFFFFE, 33, 32);
    run_op(0, OP_DIVU,   64'd100,        64'd7,          64'd14,       33, 32);
    run_op(0, OP_REMU,   64'd100,        64'd7,          64'd2,        33, 32);
    run_op(0, OP_DIV,    64'd20,         -64'sd3,        64'hFFFFFFFA, 33, 32);
    run_op(0, OP_REM,    64'd20,         -64'sd3,        64'd2,        33, 32);
    run_op(0, OP_DIVU,   64'h80000000,   64'hFFFFFFFF,   64'd0,        33, 32);
    run_op(0, OP_REMU,   64'h80000000,   64'hFFFFFFFF,   64'h80000000, 33, 32);
    // shortcuts
    run_op(0, OP_DIVU,   64'd5,          64'd0,          64'hFFFFFFFF, 1, 0);
    run_op(0, OP_REM,    64'd5,          64'd0,          64'd5,        1, 0);
    run_op(0, OP_DIV,    -64'sd7,        64'd0,          64'hFFFFFFFF, 1, 0);
    run_op(0, OP_REMU,   64'd9,          64'd0,          64'd9,        1, 0);
    run_op(0, OP_DIV,    64'h80000000,   64'hFFFFFFFF,   64'h80000000, 1, 0);
    run_op(0, OP_REM,    64'h80000000,   64'hFFFFFFFF,   64'd0,        1, 0);

    // flush in the middle of a divide, with a START in the flush cycle
    run_op(0, OP_MUL, 64'd7, -64'sd3, 64'hFFFFFFEB, 1, 0);
    @(negedge clk);
    start32 = 1'b1; op32 = OP_DIV; d1_32 = -32'sd20; d2_32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_pre_busy", 64'(busy32), 64'd1);
    flush32 = 1'b1; start32 = 1'b1; op32 = OP_MUL; d1_32 = 32'd2; d2_32 = 32'd3;
    @(negedge clk);
    flush32 = 1'b0; start32 = 1'b0;
    chk("flush_busy", 64'(busy32), 64'd0);
    chk("flush_done", 64'(done32), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hold", 64'(res32), 64'hFFFFFFEB);

    // flush in the DONE cycle: pulse stays, new request dropped
    @(negedge clk);
    start32 = 1'b1; op32 = OP_MULHU; d1_32 = 32'hFFFFFFFF; d2_32 = 32'hFFFFFFFF;
    q32.push_back('{64'hFFFFFFFE, cyc + 1});
    @(negedge clk);
    chk("fd_done", 64'(done32), 64'd1);
    flush32 = 1'b1; op32 = OP_MUL; d1_32 = 32'd3; d2_32 = 32'd3;
    @(negedge clk);
    flush32 = 1'b0; start32 = 1'b0;
    chk("fd_drop_done", 64'(done32), 64'd0);
    chk("fd_drop_busy", 64'(busy32), 64'd0);
    chk("fd_res", 64'(res32), 64'hFFFFFFFE);

    // back-to-back: START held through BUSY and the DONE cycle
    @(negedge clk);
    start32 = 1'b1; op32 = OP_DIVU; d1_32 = 32'd100; d2_32 = 32'd7;
    q32.push_back('{64'd14, cyc + 33});
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done32) seen = 1;
    end
    chk("b2b_first", 64'(seen), 64'd1);
    op32 = OP_MUL; d1_32 = 32'd6; d2_32 = 32'd7;
    q32.push_back('{64'd42, cyc + 1});
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_drain", 64'(q32.size()), 64'd0);

    // 64-bit shift-add multiplier and divider
    run_op(1, OP_MULHSU, -64'sd1,               64'd2,    64'hFFFFFFFFFFFFFFFF, 65, 64);
    run_op(1, OP_MUL,    64'h0000000100000000,  64'd3,    64'h0000000300000000, 65, 64);
    run_op(1, OP_MULHU,  64'hFFFFFFFFFFFFFFFF,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65, 64);
    run_op(1, OP_DIVU,   64'd1000,              64'd10,   64'd100,              65, 64);
    run_op(1, OP_REM,    -64'sd7,               64'd2,    64'hFFFFFFFFFFFFFFFF, 65, 64);
    run_op(1, OP_DIV,    64'h8000000000000000,  64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1, 0);
    run_op(1, OP_MULHSU, -64'sd1,               64'd2,    64'hFFFFFFFFFFFFFFFF, 65, 64);

    // reset in the middle of an iterative multiply
    @(negedge clk);
    start64 = 1'b1; op64 = OP_MULHU; d1_64 = 64'd5; d2_64 = 64'd9;
    @(negedge clk);
    start64 = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_pre_busy", 64'(busy64), 64'd1);
    rst64 = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy64), 64'd0);
    chk("rst_mid_done", 64'(done64), 64'd0);
    chk("rst_mid_res", res64, 64'd0);
    rst64 = 1'b0;
    repeat (80) @(negedge clk);
    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q64_empty", 64'(q64.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
